// File: rtl/esteira_posicionador.sv
// Conveyor belt positioner: steps the belt one position every STEP_DIV clocks while moving
// and stops automatically at the filling, quality-control and sealing stations.
module esteira_posicionador #(
    parameter int POS_W     = 4,
    parameter int STEP_DIV  = 4,
    parameter int POS_MAX   = 15,
    parameter int POS_ENCH  = 3,
    parameter int POS_CQ    = 7,
    parameter int POS_LACRE = 11
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Mover_Req,
    input  logic             Pausa,
    output logic             Motor_On,
    output logic [POS_W-1:0] Posicao,
    output logic             Motor_Parado_Pos_Enchimento,
    output logic             Motor_Parado_Pos_CQ,
    output logic             Motor_Parado_Pos_Lacre,
    output logic             Fim_Ciclo,
    output logic [7:0]       Contador_Ciclos
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_ENCH   = POS_W'(POS_ENCH);
    localparam logic [POS_W-1:0] P_CQ     = POS_W'(POS_CQ);
    localparam logic [POS_W-1:0] P_LACRE  = POS_W'(POS_LACRE);

    if (STEP_DIV < 1) begin : g_err_div
        $error("esteira_posicionador: STEP_DIV must be >= 1");
    end
    if (POS_MAX < 1 || POS_MAX > (1 << POS_W) - 1) begin : g_err_max
        $error("esteira_posicionador: POS_MAX does not fit in POS_W bits");
    end
    if (POS_ENCH < 1 || POS_CQ < 1 || POS_LACRE < 1 ||
        POS_ENCH > POS_MAX || POS_CQ > POS_MAX || POS_LACRE > POS_MAX ||
        POS_ENCH == POS_CQ || POS_ENCH == POS_LACRE || POS_CQ == POS_LACRE) begin : g_err_sta
        $error("esteira_posicionador: stations must be distinct, nonzero and <= POS_MAX");
    end

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        MOVENDO = 2'd1,
        PAUSADO = 2'd2
    } estado_t;

    estado_t          estado, estado_prox;
    logic [DIV_W-1:0] divisor, divisor_prox;
    logic [POS_W-1:0] pos_prox;
    logic [7:0]       ciclos_prox;
    logic             avanca;
    logic             volta;

    function automatic logic eh_estacao(input logic [POS_W-1:0] p);
        return (p == P_ENCH) || (p == P_CQ) || (p == P_LACRE);
    endfunction

    // The edge that releases Pausa also counts, so a pause of N cycles delays arrival by N.
    always_comb begin
        estado_prox  = estado;
        divisor_prox = divisor;
        pos_prox     = Posicao;
        ciclos_prox  = Contador_Ciclos;
        avanca       = 1'b0;
        volta        = 1'b0;

        case (estado)
            PARADO: begin
                if (Mover_Req && !Pausa) begin
                    estado_prox  = MOVENDO;
                    divisor_prox = '0;
                end
            end
            MOVENDO, PAUSADO: begin
                if (Pausa) begin
                    estado_prox = PAUSADO;
                end else begin
                    estado_prox = MOVENDO;
                    avanca      = 1'b1;
                end
            end
            default: estado_prox = PARADO;
        endcase

        if (avanca) begin
            if (divisor == DIV_LAST) begin
                divisor_prox = '0;
                if (Posicao == P_MAX) begin
                    pos_prox    = '0;
                    volta       = 1'b1;
                    ciclos_prox = Contador_Ciclos + 8'd1;
                end else begin
                    pos_prox = Posicao + 1'b1;
                end
                if (eh_estacao(pos_prox)) begin
                    estado_prox = PARADO;
                end
            end else begin
                divisor_prox = divisor + 1'b1;
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            estado                      <= PARADO;
            divisor                     <= '0;
            Posicao                     <= '0;
            Contador_Ciclos             <= '0;
            Motor_On                    <= 1'b0;
            Motor_Parado_Pos_Enchimento <= 1'b0;
            Motor_Parado_Pos_CQ         <= 1'b0;
            Motor_Parado_Pos_Lacre      <= 1'b0;
            Fim_Ciclo                   <= 1'b0;
        end else begin
            estado                      <= estado_prox;
            divisor                     <= divisor_prox;
            Posicao                     <= pos_prox;
            Contador_Ciclos             <= ciclos_prox;
            Motor_On                    <= (estado_prox == MOVENDO);
            Motor_Parado_Pos_Enchimento <= (estado_prox == PARADO) && (pos_prox == P_ENCH);
            Motor_Parado_Pos_CQ         <= (estado_prox == PARADO) && (pos_prox == P_CQ);
            Motor_Parado_Pos_Lacre      <= (estado_prox == PARADO) && (pos_prox == P_LACRE);
            Fim_Ciclo                   <= volta;
        end
    end

endmodule

// File: tb/tb_esteira_posicionador.sv
// Bench for esteira_posicionador: each move pushes its expected arrival (position, flags,
// motor-on cycles, elapsed cycles, wrap pulses, revolution count) and checks it on arrival.
module tb_esteira_posicionador;

    localparam int POS_W = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             Mover_Req;
    logic             Pausa;
    logic             Motor_On;
    logic [POS_W-1:0] Posicao;
    logic             Motor_Parado_Pos_Enchimento;
    logic             Motor_Parado_Pos_CQ;
    logic             Motor_Parado_Pos_Lacre;
    logic             Fim_Ciclo;
    logic [7:0]       Contador_Ciclos;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         pos;
        logic [2:0] flags;   // {enchimento, cq, lacre}
        int         on_cyc;
        int         elapsed;
        int         fim;
        logic [7:0] ciclos;
    } exp_t;

    exp_t sb[$];

    esteira_posicionador #(
        .POS_W(4), .STEP_DIV(4), .POS_MAX(15),
        .POS_ENCH(3), .POS_CQ(7), .POS_LACRE(11)
    ) dut (
        .clk                         (clk),
        .Reset                       (Reset),
        .Mover_Req                   (Mover_Req),
        .Pausa                       (Pausa),
        .Motor_On                    (Motor_On),
        .Posicao                     (Posicao),
        .Motor_Parado_Pos_Enchimento (Motor_Parado_Pos_Enchimento),
        .Motor_Parado_Pos_CQ         (Motor_Parado_Pos_CQ),
        .Motor_Parado_Pos_Lacre      (Motor_Parado_Pos_Lacre),
        .Fim_Ciclo                   (Fim_Ciclo),
        .Contador_Ciclos             (Contador_Ciclos)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags_now();
        return {Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Lacre};
    endfunction

    task automatic push_exp(input int pos, input logic [2:0] fl, input int on_c,
                            input int el, input int fim, input logic [7:0] cc);
        exp_t e;
        e.pos = pos; e.flags = fl; e.on_cyc = on_c; e.elapsed = el; e.fim = fim; e.ciclos = cc;
        sb.push_back(e);
    endtask

    task automatic run_to_station(input string tag, input bit drop_req);
        int   on_c = 0;
        int   el   = 0;
        int   fim  = 0;
        bit   arrived = 0;
        exp_t e;
        while (!arrived && el < 100) begin
            tick();
            el++;
            if (el == 1 && drop_req) Mover_Req = 1'b0;
            if (Motor_On) on_c++;
            if (Fim_Ciclo) fim++;
            if (flags_now() != 3'b000) arrived = 1;
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: arrival with no expected entry", tag);
            return;
        end
        e = sb.pop_front();
        if (!arrived) begin
            bad++;
            $display("FAIL %s timeout: no station flag after %0d cycles", tag, el);
        end
        total++;
        if (int'(Posicao) !== e.pos) begin
            bad++; $display("FAIL %s posicao: got %0d want %0d", tag, Posicao, e.pos);
        end
        total++;
        if (flags_now() !== e.flags) begin
            bad++; $display("FAIL %s flags: got %b want %b", tag, flags_now(), e.flags);
        end
        total++;
        if (on_c !== e.on_cyc) begin
            bad++; $display("FAIL %s motor_on_cycles: got %0d want %0d", tag, on_c, e.on_cyc);
        end
        total++;
        if (el !== e.elapsed) begin
            bad++; $display("FAIL %s elapsed: got %0d want %0d", tag, el, e.elapsed);
        end
        total++;
        if (fim !== e.fim) begin
            bad++; $display("FAIL %s fim_ciclo_pulses: got %0d want %0d", tag, fim, e.fim);
        end
        total++;
        if (Contador_Ciclos !== e.ciclos) begin
            bad++; $display("FAIL %s contador: got %0d want %0d", tag, Contador_Ciclos, e.ciclos);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({Motor_On, Fim_Ciclo, flags_now(), Posicao, Contador_Ciclos} !== '0) begin
            bad++;
            $display("FAIL %s outputs: on=%b fim=%b flags=%b pos=%0d cnt=%0d want all 0",
                     tag, Motor_On, Fim_Ciclo, flags_now(), Posicao, Contador_Ciclos);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Mover_Req = 1'b0; Pausa = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset_held");
        Reset = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset_released");
    endtask

    task automatic test_first_station;
        Mover_Req = 1'b1;
        push_exp(3, 3'b100, 12, 13, 0, 8'd0);
        run_to_station("first_station", 1'b1);
    endtask

    task automatic test_held_request;
        Mover_Req = 1'b1;
        push_exp(7, 3'b010, 16, 17, 0, 8'd0);
        run_to_station("held_to_cq", 1'b0);
        tick();
        total++;
        if (Motor_On !== 1'b1 || Posicao !== 4'd7) begin
            bad++; $display("FAIL held_depart: on=%b pos=%0d want on=1 pos=7", Motor_On, Posicao);
        end
        Mover_Req = 1'b0;
        push_exp(11, 3'b001, 15, 16, 0, 8'd0);
        run_to_station("held_to_lacre", 1'b0);
    endtask

    task automatic test_wrap(input string tag, input logic [7:0] ciclos_exp);
        Mover_Req = 1'b1;
        push_exp(3, 3'b100, 32, 33, 1, ciclos_exp);
        run_to_station(tag, 1'b1);
    endtask

    task automatic test_pause;
        int low = 0;
        int pos_moved = 0;
        Mover_Req = 1'b1;
        tick();
        Mover_Req = 1'b0;
        repeat (3) tick();
        total++;
        if (Motor_On !== 1'b1 || Posicao !== 4'd3) begin
            bad++; $display("FAIL pause_prestate: on=%b pos=%0d want on=1 pos=3", Motor_On, Posicao);
        end
        // Pausa covers the edge on which the divider would have reached terminal count.
        Pausa = 1'b1;
        repeat (5) begin
            tick();
            if (!Motor_On) low++;
            if (Posicao !== 4'd3 || Fim_Ciclo !== 1'b0) pos_moved++;
        end
        Pausa = 1'b0;
        total++;
        if (low !== 5) begin
            bad++; $display("FAIL pause_motor_low: got %0d cycles want 5", low);
        end
        total++;
        if (pos_moved !== 0) begin
            bad++; $display("FAIL pause_frozen: %0d cycles moved/pulsed want 0", pos_moved);
        end
        push_exp(7, 3'b010, 12, 13, 0, 8'd1);
        run_to_station("pause_arrival", 1'b0);
    endtask

    task automatic test_pausa_blocks;
        int moved = 0;
        Mover_Req = 1'b1;
        Pausa     = 1'b1;
        repeat (4) begin
            tick();
            if (Motor_On !== 1'b0 || flags_now() !== 3'b010) moved++;
        end
        total++;
        if (moved !== 0) begin
            bad++; $display("FAIL pausa_blocks: %0d cycles departed want 0", moved);
        end
        Pausa = 1'b0;
        tick();
        total++;
        if (Motor_On !== 1'b1) begin
            bad++; $display("FAIL pausa_release: on=%b want 1", Motor_On);
        end
        Mover_Req = 1'b0;
        push_exp(11, 3'b001, 15, 16, 0, 8'd1);
        run_to_station("pausa_release_arrival", 1'b0);
    endtask

    task automatic test_reset_mid_move;
        bit found = 0;
        Mover_Req = 1'b1;
        tick();
        Mover_Req = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (Posicao == 4'd5) found = 1;
        end
        total++;
        if (found !== 1'b1 || Motor_On !== 1'b1) begin
            bad++; $display("FAIL midmove_reach5: found=%b on=%b want 1 1", found, Motor_On);
        end
        #2;
        Reset = 1'b1;
        #1;
        check_idle_outputs("midmove_async_reset");
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        check_idle_outputs("midmove_no_restart");
    endtask

    initial begin
        test_reset();
        test_first_station();
        test_held_request();
        test_wrap("wrap_first", 8'd1);
        test_pause();
        test_pausa_blocks();
        test_wrap("wrap_second", 8'd2);
        test_reset_mid_move();
        test_first_station();
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
